// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: decodes UART byte frames into register-file write/read and ALU start commands
module rx_cmd_parser #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              PAR_ERR,
  input  logic              FRM_ERR,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [DATA_W-1:0] WrData,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  output logic              CLK_GATE_EN,
  output logic              CMD_ERR
);
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUNC, NOP_FUN
  } state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [3:0] fun_n;
  logic wr_n, rd_n, alu_n, err_n, gate_n;
  logic is_aa, is_bb, is_cc, is_dd;
  assign is_aa = RX_P_DATA == DATA_W'(8'hAA);
  assign is_bb = RX_P_DATA == DATA_W'(8'hBB);
  assign is_cc = RX_P_DATA == DATA_W'(8'hCC);
  assign is_dd = RX_P_DATA == DATA_W'(8'hDD);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      CMD_ERR     <= 1'b0;
      CLK_GATE_EN <= 1'b0;
    end else begin
      state       <= state_n;
      Address     <= addr_n;
      WrData      <= wdata_n;
      ALU_FUN     <= fun_n;
      WrEn        <= wr_n;
      RdEn        <= rd_n;
      ALU_EN      <= alu_n;
      CMD_ERR     <= err_n;
      CLK_GATE_EN <= gate_n;
    end
  end
  // gate drops the cycle after ALU_EN, unless a new ALU header arrives in that very cycle
  always_comb begin
    state_n = state;
    addr_n  = Address;
    wdata_n = WrData;
    fun_n   = ALU_FUN;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    alu_n   = 1'b0;
    err_n   = 1'b0;
    gate_n  = CLK_GATE_EN & ~ALU_EN;
    if (RX_D_VLD) begin
      if (PAR_ERR | FRM_ERR) begin
        state_n = IDLE;
        err_n   = 1'b1;
        gate_n  = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state_n = is_aa ? WR_ADDR : is_bb ? RD_ADDR : is_cc ? ALU_OPA : is_dd ? NOP_FUN : IDLE;
            err_n   = ~(is_aa | is_bb | is_cc | is_dd);
            gate_n  = gate_n | is_cc | is_dd;
          end
          WR_ADDR: begin
            addr_n  = RX_P_DATA[ADDR_W-1:0];
            state_n = WR_DATA;
          end
          WR_DATA: begin
            wdata_n = RX_P_DATA;
            wr_n    = 1'b1;
            state_n = IDLE;
          end
          RD_ADDR: begin
            addr_n  = RX_P_DATA[ADDR_W-1:0];
            rd_n    = 1'b1;
            state_n = IDLE;
          end
          ALU_OPA: begin
            addr_n  = '0;
            wdata_n = RX_P_DATA;
            wr_n    = 1'b1;
            state_n = ALU_OPB;
          end
          ALU_OPB: begin
            addr_n  = ADDR_W'(1);
            wdata_n = RX_P_DATA;
            wr_n    = 1'b1;
            state_n = ALU_FUNC;
          end
          default: begin
            fun_n   = RX_P_DATA[3:0];
            alu_n   = 1'b1;
            state_n = IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb_rx_cmd_parser: directed self-checking bench for rx_cmd_parser
module tb_rx_cmd_parser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_p_data = '0;
  logic       rx_d_vld = 1'b0;
  logic       par_err = 1'b0;
  logic       frm_err = 1'b0;
  logic [3:0] address;
  logic       wr_en, rd_en, alu_en, clk_gate_en, cmd_err;
  logic [7:0] wr_data;
  logic [3:0] alu_fun;
  logic [3:0] stb;
  int vecs = 0;
  int errs = 0;

  rx_cmd_parser #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK(clk), .RST(rst), .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
    .PAR_ERR(par_err), .FRM_ERR(frm_err), .Address(address), .WrEn(wr_en),
    .RdEn(rd_en), .WrData(wr_data), .ALU_EN(alu_en), .ALU_FUN(alu_fun),
    .CLK_GATE_EN(clk_gate_en), .CMD_ERR(cmd_err)
  );

  always #5 clk = ~clk;
  assign stb = {wr_en, rd_en, alu_en, cmd_err};

  task automatic send(input logic [7:0] b, input logic pe, input logic fe);
    rx_p_data = b;
    par_err   = pe;
    frm_err   = fe;
    rx_d_vld  = 1'b1;
    @(posedge clk);
    #1;
    rx_d_vld = 1'b0;
    par_err  = 1'b0;
    frm_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_p_data = 8'hBB;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_p_data = 8'hAA;
    rx_d_vld = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_d_vld = 1'b0;
    vecs++;
    if ({stb, clk_gate_en, address, wr_data, alu_fun} !== 21'h0) begin
      errs++;
      $display("FAIL reset_outputs got stb=%b gate=%b addr=%h data=%h fun=%h want all zero", stb, clk_gate_en, address, wr_data, alu_fun);
    end
    send(8'hBB, 0, 0);
    send(8'h03, 0, 0);
    vecs++;
    if (stb !== 4'b0100 || address !== 4'h3) begin
      errs++;
      $display("FAIL reset_cycle_byte_ignored got stb=%b addr=%h want stb=0100 addr=3", stb, address);
    end
  endtask

  task automatic test_write;
    send(8'hAA, 0, 0);
    vecs++;
    if (stb !== 4'b0000 || clk_gate_en !== 1'b0) begin
      errs++;
      $display("FAIL write_hdr got stb=%b gate=%b want 0000/0", stb, clk_gate_en);
    end
    send(8'h05, 0, 0);
    vecs++;
    if (stb !== 4'b0000) begin
      errs++;
      $display("FAIL write_addr got stb=%b want 0000", stb);
    end
    send(8'h3C, 0, 0);
    vecs++;
    if (stb !== 4'b1000 || address !== 4'h5 || wr_data !== 8'h3C) begin
      errs++;
      $display("FAIL write_data got stb=%b addr=%h data=%h want 1000/5/3c", stb, address, wr_data);
    end
    idle(1);
    vecs++;
    if (stb !== 4'b0000 || address !== 4'h5 || wr_data !== 8'h3C) begin
      errs++;
      $display("FAIL write_pulse_width got stb=%b addr=%h data=%h want 0000/5/3c", stb, address, wr_data);
    end
    send(8'hAA, 0, 0);
    send(8'hAA, 0, 0);
    send(8'hCC, 0, 0);
    vecs++;
    if (stb !== 4'b1000 || address !== 4'hA || wr_data !== 8'hCC || clk_gate_en !== 1'b0) begin
      errs++;
      $display("FAIL write_header_payload got stb=%b addr=%h data=%h gate=%b want 1000/a/cc/0", stb, address, wr_data, clk_gate_en);
    end
    send(8'hAA, 0, 0);
    idle(3);
    send(8'h36, 0, 0);
    idle(2);
    send(8'h07, 0, 0);
    vecs++;
    if (stb !== 4'b1000 || address !== 4'h6 || wr_data !== 8'h07) begin
      errs++;
      $display("FAIL write_gaps got stb=%b addr=%h data=%h want 1000/6/07", stb, address, wr_data);
    end
  endtask

  task automatic test_alu;
    send(8'hCC, 0, 0);
    vecs++;
    if (stb !== 4'b0000 || clk_gate_en !== 1'b1) begin
      errs++;
      $display("FAIL alu_hdr got stb=%b gate=%b want 0000/1", stb, clk_gate_en);
    end
    send(8'h12, 0, 0);
    vecs++;
    if (stb !== 4'b1000 || address !== 4'h0 || wr_data !== 8'h12 || clk_gate_en !== 1'b1) begin
      errs++;
      $display("FAIL alu_opa got stb=%b addr=%h data=%h gate=%b want 1000/0/12/1", stb, address, wr_data, clk_gate_en);
    end
    send(8'h34, 0, 0);
    vecs++;
    if (stb !== 4'b1000 || address !== 4'h1 || wr_data !== 8'h34) begin
      errs++;
      $display("FAIL alu_opb got stb=%b addr=%h data=%h want 1000/1/34", stb, address, wr_data);
    end
    send(8'h01, 0, 0);
    vecs++;
    if (stb !== 4'b0010 || alu_fun !== 4'h1 || clk_gate_en !== 1'b1) begin
      errs++;
      $display("FAIL alu_fun got stb=%b fun=%h gate=%b want 0010/1/1", stb, alu_fun, clk_gate_en);
    end
    idle(1);
    vecs++;
    if (stb !== 4'b0000 || clk_gate_en !== 1'b0 || alu_fun !== 4'h1) begin
      errs++;
      $display("FAIL alu_gate_fall got stb=%b gate=%b fun=%h want 0000/0/1", stb, clk_gate_en, alu_fun);
    end
  endtask

  task automatic test_back_to_back;
    send(8'hBB, 0, 0);
    send(8'h07, 0, 0);
    vecs++;
    if (stb !== 4'b0100 || address !== 4'h7) begin
      errs++;
      $display("FAIL b2b_read got stb=%b addr=%h want 0100/7", stb, address);
    end
    send(8'hDD, 0, 0);
    vecs++;
    if (stb !== 4'b0000 || clk_gate_en !== 1'b1 || address !== 4'h7) begin
      errs++;
      $display("FAIL b2b_nop_hdr got stb=%b gate=%b addr=%h want 0000/1/7", stb, clk_gate_en, address);
    end
    send(8'h08, 0, 0);
    vecs++;
    if (stb !== 4'b0010 || alu_fun !== 4'h8 || clk_gate_en !== 1'b1) begin
      errs++;
      $display("FAIL b2b_nop_fun got stb=%b fun=%h gate=%b want 0010/8/1", stb, alu_fun, clk_gate_en);
    end
    send(8'hDD, 0, 0);
    vecs++;
    if (stb !== 4'b0000 || clk_gate_en !== 1'b1) begin
      errs++;
      $display("FAIL b2b_gate_rearm got stb=%b gate=%b want 0000/1", stb, clk_gate_en);
    end
    send(8'hF3, 0, 0);
    idle(1);
    vecs++;
    if (alu_fun !== 4'h3 || clk_gate_en !== 1'b0) begin
      errs++;
      $display("FAIL b2b_fun_low_nibble got fun=%h gate=%b want 3/0", alu_fun, clk_gate_en);
    end
  endtask

  task automatic test_errors;
    send(8'hAA, 0, 0);
    send(8'h03, 0, 0);
    send(8'h55, 1, 0);
    vecs++;
    if (stb !== 4'b0001 || wr_data !== 8'h34) begin
      errs++;
      $display("FAIL err_par_data got stb=%b data=%h want 0001/34", stb, wr_data);
    end
    send(8'hAA, 0, 0);
    send(8'h02, 0, 0);
    send(8'h11, 0, 0);
    vecs++;
    if (stb !== 4'b1000 || address !== 4'h2 || wr_data !== 8'h11) begin
      errs++;
      $display("FAIL err_recover_write got stb=%b addr=%h data=%h want 1000/2/11", stb, address, wr_data);
    end
    send(8'hCC, 0, 0);
    send(8'h99, 0, 1);
    vecs++;
    if (stb !== 4'b0001 || clk_gate_en !== 1'b0 || wr_data !== 8'h11) begin
      errs++;
      $display("FAIL err_frm_in_alu got stb=%b gate=%b data=%h want 0001/0/11", stb, clk_gate_en, wr_data);
    end
    send(8'hBB, 1, 1);
    vecs++;
    if (stb !== 4'b0001) begin
      errs++;
      $display("FAIL err_in_idle got stb=%b want 0001", stb);
    end
    send(8'h0C, 0, 0);
    vecs++;
    if (stb !== 4'b0001) begin
      errs++;
      $display("FAIL err_header_discarded got stb=%b want 0001", stb);
    end
  endtask

  task automatic test_unknown;
    send(8'h7E, 0, 0);
    vecs++;
    if (stb !== 4'b0001) begin
      errs++;
      $display("FAIL unknown_cmd got stb=%b want 0001", stb);
    end
    idle(1);
    vecs++;
    if (stb !== 4'b0000) begin
      errs++;
      $display("FAIL unknown_pulse_width got stb=%b want 0000", stb);
    end
    send(8'hBB, 0, 0);
    send(8'h09, 0, 0);
    vecs++;
    if (stb !== 4'b0100 || address !== 4'h9) begin
      errs++;
      $display("FAIL unknown_stays_idle got stb=%b addr=%h want 0100/9", stb, address);
    end
  endtask

  task automatic test_reset_midframe;
    send(8'hCC, 0, 0);
    send(8'h01, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vecs++;
    if ({stb, clk_gate_en, address, wr_data, alu_fun} !== 21'h0) begin
      errs++;
      $display("FAIL midframe_reset got stb=%b gate=%b addr=%h data=%h fun=%h want all zero", stb, clk_gate_en, address, wr_data, alu_fun);
    end
    send(8'hBB, 0, 0);
    send(8'h04, 0, 0);
    vecs++;
    if (stb !== 4'b0100 || address !== 4'h4 || clk_gate_en !== 1'b0) begin
      errs++;
      $display("FAIL midframe_reset_read got stb=%b addr=%h gate=%b want 0100/4/0", stb, address, clk_gate_en);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_write;
    test_alu;
    test_back_to_back;
    test_errors;
    test_unknown;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
